// File: rtl/fetch_unit_if.sv
// Fetch unit bus: program load port, start/stop/redirect control and
// the instruction output handshake. Master drives, slave is the fetch unit.
interface fetch_unit_if #(
    parameter int INST_W = 36,
    parameter int ADDR_W = 5
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [INST_W-1:0] load_data;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              stop;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              out_ready;
    logic              out_valid;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic [ADDR_W-1:0] pc_out;
    logic              busy;

    modport master (
        output load_en, load_addr, load_data,
        output start, start_addr, stop,
        output redirect_valid, redirect_addr,
        output out_ready,
        input  out_valid, inst_out, inst_pc,
        input  pc_out, busy
    );

    modport slave (
        input  load_en, load_addr, load_data,
        input  start, start_addr, stop,
        input  redirect_valid, redirect_addr,
        input  out_ready,
        output out_valid, inst_out, inst_pc,
        output pc_out, busy
    );
endinterface

// File: rtl/fetch_unit.sv
// Sequenced PC -> MAR -> memory -> MDR -> IR fetch unit with valid/ready output.
// Optional redirect support is enabled by defining FETCH_REDIRECT_EN.
module fetch_unit #(
    parameter int INST_W = 36,
    parameter int ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_MEM,
        S_LATCH,
        S_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] r_mar;
    logic [INST_W-1:0] r_mdr;
    logic [INST_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_ir_pc;
    logic              r_out_valid;
    logic              w_out_valid_nxt;
    logic              w_mar_ld;
    logic              w_mdr_ld;
    logic              w_ir_ld;
    logic              w_handshake;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_redirect_addr;
    logic [INST_W-1:0] r_mem [DEPTH];

`ifdef FETCH_REDIRECT_EN
    assign w_redirect      = bus.redirect_valid && (r_state != S_IDLE);
    assign w_redirect_addr = bus.redirect_addr;
`else
    logic w_unused_redirect;
    assign w_unused_redirect = ^{bus.redirect_valid, bus.redirect_addr};
    assign w_redirect        = 1'b0;
    assign w_redirect_addr   = '0;
`endif

    assign w_handshake = r_out_valid & bus.out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_out_valid_nxt = r_out_valid;
        w_mar_ld        = 1'b0;
        w_mdr_ld        = 1'b0;
        w_ir_ld         = 1'b0;
        if (bus.stop) begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b0;
        end else if (w_redirect) begin
            // squashes any in-flight or held instruction
            w_state_nxt     = S_ADDR;
            w_pc_nxt        = w_redirect_addr;
            w_out_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_pc_nxt    = bus.start_addr;
                        w_state_nxt = S_ADDR;
                    end
                end
                S_ADDR: begin
                    w_mar_ld    = 1'b1;
                    w_state_nxt = S_MEM;
                end
                S_MEM: begin
                    w_mdr_ld    = 1'b1;
                    w_state_nxt = S_LATCH;
                end
                S_LATCH: begin
                    w_ir_ld         = 1'b1;
                    w_pc_nxt        = r_pc + PC_ONE;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_WAIT;
                end
                S_WAIT: begin
                    if (w_handshake) begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = S_ADDR;
                    end
                end
                default: begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_ir        <= '0;
            r_ir_pc     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_out_valid <= w_out_valid_nxt;
            if (w_mar_ld) begin
                r_mar <= r_pc;
            end
            if (w_mdr_ld) begin
                r_mdr <= r_mem[r_mar];
            end
            if (w_ir_ld) begin
                r_ir    <= r_mdr;
                r_ir_pc <= r_mar;
            end
        end
    end

    // no reset: program contents survive rst_n; read-first via NBA ordering
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.inst_out  = r_ir;
    assign bus.inst_pc   = r_ir_pc;
    assign bus.pc_out    = r_pc;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus randomized
// program contents, start addresses and consumer back-pressure.
module tb_fetch_unit;
    localparam int IW    = 36;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fetch_unit_if #(.INST_W(IW), .ADDR_W(AW)) bus();

    fetch_unit #(.INST_W(IW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mon_e;
    logic [IW-1:0] model_mem [DEPTH];
    int            nchk = 0;
    int            nfail = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor: transfer happens on the next rising edge
    always @(negedge clk) begin
        if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_output: got pc %0h data %0h expected none",
                         bus.inst_pc, bus.inst_out);
            end else begin
                mon_e = sbq.pop_front();
                check("out_pc", 64'(bus.inst_pc), 64'(mon_e.pc));
                check("out_data", 64'(bus.inst_out), 64'(mon_e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        tick();
        bus.load_en   = 1'b0;
        model_mem[a]  = d;
    endtask

    // expected stream: consecutive addresses, wrapping modulo depth
    task automatic push_seq(input logic [AW-1:0] a, input int n);
        exp_t          e;
        logic [AW-1:0] p;
        p = a;
        for (int i = 0; i < n; i++) begin
            e.pc   = p;
            e.data = model_mem[p];
            sbq.push_back(e);
            p = p + 1'b1;
        end
    endtask

    task automatic wait_drain(input int bound, input bit rnd);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < bound) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        check("drain_timeout", 64'(sbq.size()), 64'd0);
        sbq.delete();
    endtask

    task automatic wait_valid(input int bound);
        int k;
        k = 0;
        while (bus.out_valid !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        check("valid_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic halt();
        bus.out_ready = 1'b0;
        bus.stop      = 1'b1;
        tick();
        bus.stop      = 1'b0;
    endtask

    task automatic run_fetch(input logic [AW-1:0] a, input int n, input bit rnd);
        push_seq(a, n);
        bus.out_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.start      = 1'b1;
        bus.start_addr = a;
        tick();
        bus.start      = 1'b0;
        wait_drain(n * 24 + 24, rnd);
        halt();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_inst"}, 64'(bus.inst_out), 64'd0);
        check({tag, "_ipc"}, 64'(bus.inst_pc), 64'd0);
        check({tag, "_pc"}, 64'(bus.pc_out), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [63:0] r;
        bus.load_en        = 1'b0;
        bus.load_addr      = '0;
        bus.load_data      = '0;
        bus.start          = 1'b0;
        bus.start_addr     = '0;
        bus.stop           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.out_ready      = 1'b0;

        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // sequential fetch of the whole memory with wrap
        for (int i = 0; i < DEPTH; i++) load(AW'(i), IW'(36'hA0 + i));
        push_seq(0, 33);
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        bus.start_addr = '0;
        tick();
        bus.start      = 1'b0;
        check("lat_busy", 64'(bus.busy), 64'd1);
        check("lat_e0", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_e1", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_e2", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_e3", 64'(bus.out_valid), 64'd1);
        wait_drain(33 * 4 + 20, 1'b0);
        halt();
        check("wrap_pc", 64'(bus.pc_out), 64'd1);
        check("stop_busy", 64'(bus.busy), 64'd0);

        // back-pressure at address 4
        push_seq(4, 1);
        bus.start      = 1'b1;
        bus.start_addr = 5'd4;
        tick();
        bus.start      = 1'b0;
        wait_valid(20);
        for (int k = 0; k < 10; k++) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_ipc", 64'(bus.inst_pc), 64'd4);
            check("hold_inst", 64'(bus.inst_out), 64'(model_mem[4]));
            check("hold_pc", 64'(bus.pc_out), 64'd5);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("one_xfer", 64'(sbq.size()), 64'd0);
        check("after_xfer", 64'(bus.out_valid), 64'd0);
        repeat (6) tick();
        check("next_ipc", 64'(bus.inst_pc), 64'd5);
        halt();

        // write and read of address 6 on the same edge
        load(5'd6, 36'h1);
        push_seq(6, 1);
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        bus.start_addr = 5'd6;
        tick();
        bus.start      = 1'b0;
        tick();
        bus.load_en    = 1'b1;
        bus.load_addr  = 5'd6;
        bus.load_data  = 36'hF_FFFF_FFFF;
        tick();
        bus.load_en    = 1'b0;
        model_mem[6]   = 36'hF_FFFF_FFFF;
        wait_drain(30, 1'b0);
        halt();
        run_fetch(5'd6, 1, 1'b0);

        // stop during the memory read of address 9
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        bus.start_addr = 5'd9;
        tick();
        bus.start      = 1'b0;
        tick();
        bus.stop       = 1'b1;
        tick();
        bus.stop       = 1'b0;
        check("stop_busy9", 64'(bus.busy), 64'd0);
        check("stop_valid9", 64'(bus.out_valid), 64'd0);
        check("stop_pc9", 64'(bus.pc_out), 64'd9);
        repeat (6) tick();
        check("stop_idle9", 64'(bus.out_valid), 64'd0);
        run_fetch(5'd9, 1, 1'b0);

        // redirect while an instruction is held
        bus.out_ready  = 1'b0;
        bus.start      = 1'b1;
        bus.start_addr = 5'd12;
        tick();
        bus.start      = 1'b0;
        wait_valid(20);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 5'd20;
        tick();
        bus.redirect_valid = 1'b0;
`ifdef FETCH_REDIRECT_EN
        check("redir_valid", 64'(bus.out_valid), 64'd0);
        check("redir_pc", 64'(bus.pc_out), 64'd20);
        push_seq(20, 2);
`else
        check("redir_valid", 64'(bus.out_valid), 64'd1);
        check("redir_pc", 64'(bus.pc_out), 64'd13);
        push_seq(12, 2);
`endif
        bus.out_ready = 1'b1;
        wait_drain(40, 1'b0);
        halt();

        // asynchronous reset while in LATCH
        bus.start      = 1'b1;
        bus.start_addr = 5'd15;
        tick();
        bus.start      = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_valid", 64'(bus.out_valid), 64'd0);
        check("post_rst_busy", 64'(bus.busy), 64'd0);
        run_fetch(5'd15, 2, 1'b0);

        // random program, start points and back-pressure
        for (int i = 0; i < DEPTH; i++) begin
            r = {$urandom(), $urandom()};
            load(AW'(i), r[IW-1:0]);
        end
        for (int t = 0; t < 8; t++) begin
            run_fetch(AW'($urandom_range(0, DEPTH - 1)), $urandom_range(1, 8), 1'b1);
        end
        repeat (4) tick();
        check("final_queue", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
